// File: rtl/preset_loader.sv
// preset_loader: seeds the four 4x4 tiles of the 16x16 Life board from a
// small built-in pattern ROM. It drives the selector-side write port of the
// block memory and raises hold_run while a load is under way, so the top
// level can hold off generation stepping.
//
// Write port handshake: mem_write_enb is a one-way strobe with no ready.
// The block memory takes mem_array_sel/mem_alive on every rising clock edge
// where mem_write_enb is high. A load is exactly NUM_TILES back-to-back
// strobes for tiles 0..NUM_TILES-1, followed by a one-cycle done pulse.
// mem_array_sel and mem_alive are held at zero whenever the strobe is low.
module preset_loader #(
    parameter int          NUM_TILES      = 4,
    parameter bit          AUTO_LOAD      = 1'b1,
    parameter logic [3:0]  DEFAULT_PRESET = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_req,
    input  logic [3:0]  preset_sel,
    output logic        mem_write_enb,
    output logic [1:0]  mem_array_sel,
    output logic [15:0] mem_alive,
    output logic        busy,
    output logic        done,
    output logic        hold_run
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Index of the final tile; the write phase ends once it has been shown.
    localparam logic [1:0] LAST_TILE = 2'(NUM_TILES - 1);

    state_t     state;
    logic [1:0] tile;          // next tile to present while in WRITE
    logic [3:0] preset_q;      // preset captured when the load starts
    logic       load_pending;  // automatic load owed after reset release

    logic       sync_s1;
    logic       sync_s2;
    logic       sync_prev;
    logic       req_edge;

    logic       start;
    logic [3:0] start_preset;

    // Two-flop synchroniser for the button level plus a previous-value flop
    // for rising-edge detection. prev follows s2 in every state, so a held
    // button produces exactly one edge no matter when the load finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_s1   <= 1'b0;
            sync_s2   <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_s1   <= load_req;
            sync_s2   <= sync_s1;
            sync_prev <= sync_s2;
        end
    end

    assign req_edge = sync_s2 & ~sync_prev;

    // Pattern ROM. Bit index is row*4+col with row 0 at the top, so the
    // low nibble of each word is the top row of the tile.
    function automatic logic [15:0] rom_lookup(input logic [3:0] preset,
                                               input logic [1:0] t);
        logic [15:0] word;
        word = 16'h0000;
        case (preset)
            4'd1:    word = (t == 2'd0) ? 16'h0070 : 16'h0000; // blinker
            4'd2:    word = (t == 2'd0) ? 16'h0742 : 16'h0000; // glider
            4'd3:    word = 16'h0660;                          // block
            4'd4:    word = 16'hFFFF;                          // all alive
            4'd15:   word = 16'hA5A5;                          // checker
            default: word = 16'h0000;                          // 0, 5..14
        endcase
        return word;
    endfunction

    // A pending automatic load takes priority over a button edge; both
    // only count while idle, so edges during WRITE or DONE are dropped.
    always_comb begin
        start        = (state == IDLE) && (load_pending || req_edge);
        start_preset = load_pending ? DEFAULT_PRESET : preset_sel;
    end

    // Loader FSM with registered outputs. Tile 0 is presented on the very
    // edge that leaves IDLE, which is why the ROM is indexed with the
    // incoming preset there and with the latched copy afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tile          <= 2'd0;
            preset_q      <= 4'd0;
            load_pending  <= AUTO_LOAD;
            mem_write_enb <= 1'b0;
            mem_array_sel <= 2'd0;
            mem_alive     <= 16'h0000;
            busy          <= 1'b0;
            done          <= 1'b0;
            hold_run      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_write_enb <= 1'b0;
                    mem_array_sel <= 2'd0;
                    mem_alive     <= 16'h0000;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                    hold_run      <= 1'b0;
                    tile          <= 2'd0;
                    if (start) begin
                        state         <= WRITE;
                        preset_q      <= start_preset;
                        load_pending  <= 1'b0;
                        mem_write_enb <= 1'b1;
                        mem_array_sel <= 2'd0;
                        mem_alive     <= rom_lookup(start_preset, 2'd0);
                        tile          <= 2'd1;
                        busy          <= 1'b1;
                        hold_run      <= 1'b1;
                    end
                end

                WRITE: begin
                    if (mem_array_sel == LAST_TILE) begin
                        state         <= DONE;
                        mem_write_enb <= 1'b0;
                        mem_array_sel <= 2'd0;
                        mem_alive     <= 16'h0000;
                        done          <= 1'b1;
                        tile          <= 2'd0;
                    end else begin
                        mem_array_sel <= tile;
                        mem_alive     <= rom_lookup(preset_q, tile);
                        tile          <= tile + 2'd1;
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    hold_run <= 1'b0;
                end

                default: begin
                    state         <= IDLE;
                    mem_write_enb <= 1'b0;
                    mem_array_sel <= 2'd0;
                    mem_alive     <= 16'h0000;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                    hold_run      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/preset_loader.md
Name: preset_loader

Overview:
- Seeds the 16x16 Life board (four 4x4 tiles) in the block memory from a small built-in pattern ROM.
- Sits directly upstream of the block memory's selector-side write port, alongside the controller.
- A button-level load request, or an optional automatic load after reset, writes all four tiles on consecutive cycles.
- While a load is in progress it asserts hold_run, so the top level can gate generation stepping.

Parameters:
- NUM_TILES, 4, number of 4x4 tiles written per load; tile index width is 2.
- AUTO_LOAD, 1, when 1 a load of DEFAULT_PRESET starts automatically after reset deasserts.
- DEFAULT_PRESET, 4'd0, preset used by the automatic load.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- load_req  input  1  asynchronous level from a button; a rising edge requests a load.
- preset_sel  input  4  preset number, latched when a load starts.
- mem_write_enb  output  1  write strobe to the block memory.
- mem_array_sel  output  2  tile index being written.
- mem_alive  output  16  tile contents; bit index = row*4+col, row 0 is the top row.
- busy  output  1  high in WRITE and DONE.
- done  output  1  one-cycle pulse when the last tile has been written.
- hold_run  output  1  equal to busy; used to gate run.

Behaviour:
- Input conditioning:
  - load_req passes through two synchroniser flops (s1, s2) and then a previous-value flop (prev).
  - req_edge = s2 & ~prev.
  - All three flops reset to 0.
- Pattern ROM (combinational on the latched preset and tile index):
  - 0: all tiles 16'h0000.
  - 1: tile0 16'h0070 (blinker), other tiles 0.
  - 2: tile0 16'h0742 (glider), other tiles 0.
  - 3: every tile 16'h0660 (block).
  - 4: every tile 16'hFFFF.
  - 15: every tile 16'hA5A5.
  - 5 to 14: all tiles 0.
- FSM states: IDLE, WRITE, DONE. All outputs are registered.
- IDLE:
  - All outputs 0.
  - On req_edge: latch preset_sel, set tile=0, go to WRITE.
  - If AUTO_LOAD=1, the first cycle after reset release acts as a start with DEFAULT_PRESET; this is a pending flag set by reset and cleared on start.
- WRITE:
  - mem_write_enb=1, mem_array_sel=tile, mem_alive=ROM(preset, tile).
  - tile increments each cycle.
  - After tile NUM_TILES-1 has been presented, go to DONE. WRITE lasts exactly NUM_TILES cycles with no gaps.
- DONE:
  - done=1, mem_write_enb=0, busy stays 1 for this cycle.
  - Then return to IDLE.
- Latency:
  - Clock edge k first samples load_req=1 into s1; s2=1 after edge k+1.
  - mem_write_enb is high from edge k+2 through edge k+6 (cycles k+2..k+5).
  - done is high for the cycle after edge k+6.
- Boundary conditions:
  - req_edge in WRITE or DONE is ignored, not queued.
  - prev keeps tracking in every state, so holding the button never retriggers; a new press needs load_req low for at least 1 sampled cycle.
  - A change on preset_sel during WRITE has no effect, because the value is latched at start.
  - Reset mid-load: all outputs drop to 0 immediately (asynchronously), FSM goes to IDLE, and the partial load is abandoned. With AUTO_LOAD=1 a full load restarts after release.
  - mem_array_sel and mem_alive are 0 whenever mem_write_enb=0.

Test Plan:
- Reset with AUTO_LOAD=1, DEFAULT_PRESET=0, load_req=0 -> after release, 4 writes of 16'h0000 to tiles 0,1,2,3 on consecutive cycles, then done for 1 cycle, busy=hold_run=1 for 5 cycles.
- preset_sel=2, pulse load_req high for 3 cycles -> writes start at edge k+2; tile0=16'h0742, tiles1-3=0; exactly one load.
- preset_sel=3, press, then change preset_sel to 4 during WRITE -> all four tiles 16'h0660.
- Hold load_req high for 20 cycles, then give a second press during WRITE -> only one load; a release followed by a new press after DONE -> a second load.
- Assert reset during the tile-1 write -> mem_write_enb=0 in the same cycle; after release with AUTO_LOAD=1, a full load of tiles 0..3 runs and no tile is skipped.
- preset_sel=15, press -> all tiles 16'hA5A5; preset_sel=9, press -> all tiles 0.
